// File: rtl/traffic_light_ctrl_if.sv
// Lamp, sensor and request bundle for the intersection controller.
// The master side is the field wiring; the slave side is the controller.
interface traffic_light_ctrl_if;
  logic       sensor_b;
  logic       ped_req;
  logic       flash_en;
  logic [2:0] light_a;
  logic [2:0] light_b;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (
    output sensor_b, ped_req, flash_en,
    input  light_a, light_b, walk,
    input  ped_pending, phase
  );

  modport slave (
    input  sensor_b, ped_req, flash_en,
    output light_a, light_b, walk,
    output ped_pending, phase
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-approach intersection controller with pedestrian walk phase,
// all-red clearance and flashing night mode; lamp outputs registered.
module traffic_light_ctrl #(
  parameter int CNT_W         = 8,
  parameter int GREEN_A_TICKS = 8,
  parameter int GREEN_B_TICKS = 6,
  parameter int YELLOW_TICKS  = 3,
  parameter int ALLRED_TICKS  = 2,
  parameter int PED_TICKS     = 5,
  parameter int FLASH_TICKS   = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  traffic_light_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    ALLRED_1 = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    ALLRED_2 = 3'd5,
    PED_WALK = 3'd6,
    FLASH    = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] GA_END = CNT_W'(GREEN_A_TICKS - 1);
  localparam logic [CNT_W-1:0] GB_END = CNT_W'(GREEN_B_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_END  = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] AR_END = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] P_END  = CNT_W'(PED_TICKS - 1);
  localparam logic [CNT_W-1:0] F_END  = CNT_W'(FLASH_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_q, ped_d;
  logic             blink_q, blink_d;
  logic [2:0]       la_q, la_d;
  logic [2:0]       lb_q, lb_d;
  logic             walk_q, walk_d;
  logic             walk_entry;

  // State, dwell counter, request latch and lamp registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ALLRED_2;
      cnt_q   <= '0;
      ped_q   <= 1'b0;
      blink_q <= 1'b0;
      la_q    <= 3'b100;
      lb_q    <= 3'b100;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ped_q   <= ped_d;
      blink_q <= blink_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
      walk_q  <= walk_d;
    end
  end

  // Next state, dwell counter, blink phase and pedestrian latch.
  always_comb begin
    state_d = state_q;
    blink_d = blink_q;
    unique case (state_q)
      A_GREEN:
        if (cnt_q == GA_END &&
            (bus.sensor_b || ped_q || bus.flash_en))
          state_d = A_YELLOW;
      A_YELLOW:
        if (cnt_q == Y_END) state_d = ALLRED_1;
      ALLRED_1:
        if (cnt_q == AR_END) begin
          if (bus.flash_en)  state_d = FLASH;
          else if (ped_q)    state_d = PED_WALK;
          else               state_d = B_GREEN;
        end
      B_GREEN:
        if (cnt_q == GB_END) state_d = B_YELLOW;
      B_YELLOW:
        if (cnt_q == Y_END) state_d = ALLRED_2;
      ALLRED_2:
        if (cnt_q == AR_END) begin
          if (bus.flash_en) state_d = FLASH;
          else              state_d = A_GREEN;
        end
      PED_WALK:
        if (cnt_q == P_END) state_d = ALLRED_2;
      FLASH:
        if (cnt_q == F_END) begin
          if (!bus.flash_en) state_d = ALLRED_2;
          else               blink_d = ~blink_q;
        end
      default: state_d = ALLRED_2;
    endcase

    // Counter restarts on entry and per blink half-period;
    // A green parks at its minimum dwell while waiting for demand.
    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q == FLASH && cnt_q == F_END)
      cnt_d = '0;
    else if (state_q == A_GREEN && cnt_q == GA_END)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 1'b1;

    if (state_d == FLASH && state_q != FLASH)
      blink_d = 1'b1;

    walk_entry = (state_d == PED_WALK) && (state_q != PED_WALK);
    ped_d = bus.ped_req | (ped_q & ~walk_entry);
  end

  // Lamp pattern for the state being entered, so lamps match phase.
  always_comb begin
    la_d   = 3'b100;
    lb_d   = 3'b100;
    walk_d = 1'b0;
    unique case (state_d)
      A_GREEN:  la_d = 3'b001;
      A_YELLOW: la_d = 3'b010;
      B_GREEN:  lb_d = 3'b001;
      B_YELLOW: lb_d = 3'b010;
      PED_WALK: walk_d = 1'b1;
      FLASH: begin
        la_d = blink_d ? 3'b010 : 3'b000;
        lb_d = blink_d ? 3'b100 : 3'b000;
      end
      default: ;
    endcase
  end

  assign bus.light_a     = la_q;
  assign bus.light_b     = lb_q;
  assign bus.walk        = walk_q;
  assign bus.ped_pending = ped_q;
  assign bus.phase       = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: phase sequences, lamps,
// pedestrian latch, flash mode and mid-run reset.
module tb_traffic_light_ctrl;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  traffic_light_ctrl_if bus ();

  traffic_light_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] lamp_a(input logic [2:0] p);
    if (p == 3'd0)      return 3'b001;
    else if (p == 3'd1) return 3'b010;
    else                return 3'b100;
  endfunction

  function automatic logic [2:0] lamp_b(input logic [2:0] p);
    if (p == 3'd3)      return 3'b001;
    else if (p == 3'd4) return 3'b010;
    else                return 3'b100;
  endfunction

  // Expect phase p (non-flash) for n cycles, then advance.
  task automatic run(input string tag,
                     input logic [2:0] p,
                     input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, ".phase"}, 8'(bus.phase), 8'(p));
      chk({tag, ".la"}, 8'(bus.light_a), 8'(lamp_a(p)));
      chk({tag, ".lb"}, 8'(bus.light_b), 8'(lamp_b(p)));
      chk({tag, ".walk"}, 8'(bus.walk), 8'(p == 3'd6));
      chk({tag, ".safe"},
          8'(bus.light_a != 3'b100 && bus.light_b != 3'b100),
          8'(0));
      tick();
    end
  endtask

  // Expect flash with the given blink level for n cycles.
  task automatic flash(input string tag,
                       input logic lit,
                       input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, ".phase"}, 8'(bus.phase), 8'(7));
      chk({tag, ".la"}, 8'(bus.light_a),
          8'(lit ? 3'b010 : 3'b000));
      chk({tag, ".lb"}, 8'(bus.light_b),
          8'(lit ? 3'b100 : 3'b000));
      chk({tag, ".walk"}, 8'(bus.walk), 8'(0));
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.sensor_b = 1'b0;
    bus.ped_req  = 1'b0;
    bus.flash_en = 1'b0;

    tick(); tick(); tick();
    chk("rst.ped", 8'(bus.ped_pending), 8'(0));
    rst_n = 1'b1;
    run("rst", 3'd5, 2);
    run("idleA", 3'd0, 110);

    // Vehicle demand on B: two full 24-cycle periods.
    bus.sensor_b = 1'b1;
    run("dem.A", 3'd0, 1);
    run("dem.AY", 3'd1, 3);
    run("dem.R1", 3'd2, 2);
    run("dem.BG", 3'd3, 6);
    run("dem.BY", 3'd4, 3);
    run("dem.R2", 3'd5, 2);
    for (int k = 0; k < 2; k++) begin
      run("per.AG", 3'd0, 8);
      run("per.AY", 3'd1, 3);
      run("per.R1", 3'd2, 2);
      run("per.BG", 3'd3, 6);
      run("per.BY", 3'd4, 3);
      run("per.R2", 3'd5, 2);
    end

    // Single pedestrian pulse at A green cycle 2.
    bus.sensor_b = 1'b0;
    run("ped.AG", 3'd0, 1);
    chk("ped.pre", 8'(bus.ped_pending), 8'(0));
    bus.ped_req = 1'b1;
    run("ped.AG", 3'd0, 1);
    bus.ped_req = 1'b0;
    chk("ped.set", 8'(bus.ped_pending), 8'(1));
    run("ped.AG", 3'd0, 6);
    run("ped.AY", 3'd1, 3);
    run("ped.R1", 3'd2, 2);
    chk("ped.clr", 8'(bus.ped_pending), 8'(0));
    run("ped.W", 3'd6, 5);
    run("ped.R2", 3'd5, 2);

    // Pedestrian and B vehicle together: walk first.
    bus.ped_req  = 1'b1;
    bus.sensor_b = 1'b1;
    run("both.AG", 3'd0, 1);
    bus.ped_req = 1'b0;
    run("both.AG", 3'd0, 7);
    run("both.AY", 3'd1, 3);
    run("both.R1", 3'd2, 2);
    run("both.W", 3'd6, 5);
    run("both.R2", 3'd5, 2);
    run("both.AG2", 3'd0, 8);
    run("both.AY2", 3'd1, 3);
    run("both.R1b", 3'd2, 2);

    // Flash requested during B green.
    bus.sensor_b = 1'b0;
    run("fl.BG", 3'd3, 3);
    bus.flash_en = 1'b1;
    run("fl.BG", 3'd3, 3);
    run("fl.BY", 3'd4, 3);
    run("fl.R2", 3'd5, 2);
    flash("fl.on", 1'b1, 4);
    flash("fl.off", 1'b0, 4);
    flash("fl.on2", 1'b1, 2);
    bus.flash_en = 1'b0;
    flash("fl.end", 1'b1, 2);
    run("fl.R2x", 3'd5, 2);

    // Request on the walk entry edge is held for a second walk.
    bus.ped_req = 1'b1;
    run("rl.AG", 3'd0, 1);
    bus.ped_req = 1'b0;
    run("rl.AG", 3'd0, 7);
    run("rl.AY", 3'd1, 3);
    run("rl.R1", 3'd2, 1);
    bus.ped_req = 1'b1;
    run("rl.R1", 3'd2, 1);
    bus.ped_req = 1'b0;
    chk("rl.hold", 8'(bus.ped_pending), 8'(1));
    run("rl.W", 3'd6, 5);
    run("rl.R2", 3'd5, 2);
    chk("rl.keep", 8'(bus.ped_pending), 8'(1));
    run("rl.AG2", 3'd0, 8);
    run("rl.AY2", 3'd1, 3);
    run("rl.R1b", 3'd2, 2);
    chk("rl.clr", 8'(bus.ped_pending), 8'(0));
    run("rl.W2", 3'd6, 5);
    run("rl.R2b", 3'd5, 2);

    // Reset pulse in B green cycle 3 with a request latched.
    bus.sensor_b = 1'b1;
    run("mr.AG", 3'd0, 8);
    run("mr.AY", 3'd1, 3);
    run("mr.R1", 3'd2, 2);
    bus.ped_req = 1'b1;
    run("mr.BG", 3'd3, 1);
    bus.ped_req = 1'b0;
    run("mr.BG", 3'd3, 1);
    chk("mr.pend", 8'(bus.ped_pending), 8'(1));
    rst_n = 1'b0;
    bus.sensor_b = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr.ped", 8'(bus.ped_pending), 8'(0));
    run("mr.R2", 3'd5, 2);
    run("mr.AG", 3'd0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
